// File: rtl/whack_input_decoder.sv
// Switch front end for whack-a-mole: per-switch sync + debounce lanes feeding a
// pending-event table that is drained one event at a time over valid/ready.

module whack_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_sw,
  output logic o_stable,
  output logic o_chg,
  output logic o_new
);
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             w_diff;
  logic             w_done;

  assign w_diff   = r_sync[1] ^ r_stable;
  assign w_done   = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign o_stable = r_stable;
  assign o_chg    = w_done;
  assign o_new    = r_sync[1];

  // Any return to the stable level restarts the count, so bounces never accumulate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_sw};
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

module whack_input_decoder #(
  parameter int N_SW            = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_SW-1:0] sw,
  output logic [N_SW-1:0] sw_stable,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [3:0]      evt_index,
  output logic            evt_level,
  output logic            evt_overrun
);
  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t          r_state, w_state_nxt;
  logic [N_SW-1:0] w_chg, w_new, w_clr, w_ovr;
  logic [N_SW-1:0] r_pend, r_plev;
  logic [3:0]      r_index, w_sel;
  logic            r_level, r_overrun;
  logic            w_load;

  genvar gi;
  generate
    for (gi = 0; gi < N_SW; gi++) begin : g_lane
      whack_debounce_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .i_sw    (sw[gi]),
        .o_stable(sw_stable[gi]),
        .o_chg   (w_chg[gi]),
        .o_new   (w_new[gi])
      );
    end
  endgenerate

  // Lowest set pending index wins; loop runs high-to-low so the last hit is the lowest.
  always_comb begin
    w_sel = '0;
    for (int i = N_SW - 1; i >= 0; i--) begin
      if (r_pend[i]) w_sel = 4'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: if (|r_pend) begin
        w_load      = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND: if (evt_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A clear colliding with a new change loses: the entry stays pending with the new level.
  always_comb begin
    w_clr = '0;
    if (w_load) w_clr[w_sel] = 1'b1;
    w_ovr = w_chg & r_pend & ~w_clr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_pend    <= '0;
      r_plev    <= '0;
      r_index   <= '0;
      r_level   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= (r_pend & ~w_clr) | w_chg;
      r_plev  <= (r_plev & ~w_chg) | (w_new & w_chg);
      if (w_load) begin
        r_index <= w_sel;
        r_level <= r_plev[w_sel];
      end
      if (|w_ovr) r_overrun <= 1'b1;
    end
  end

  assign evt_valid   = (r_state == S_SEND);
  assign evt_index   = r_index;
  assign evt_level   = r_level;
  assign evt_overrun = r_overrun;
endmodule

// File: tb/tb_whack_input_decoder.sv
// Directed bench for whack_input_decoder with DEBOUNCE_CYCLES=4; edge 0 is the
// edge just before a switch change is driven.

module tb_whack_input_decoder;
  logic        clk;
  logic        reset_n;
  logic [15:0] sw;
  logic [15:0] sw_stable;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_index;
  logic        evt_level;
  logic        evt_overrun;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] evq[$];

  whack_input_decoder #(
    .N_SW(16), .DEBOUNCE_CYCLES(4), .CNT_W(3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw         (sw),
    .sw_stable  (sw_stable),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_index  (evt_index),
    .evt_level  (evt_level),
    .evt_overrun(evt_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every handshake as {index, level}.
  always @(posedge clk) begin
    if (reset_n && evt_valid && evt_ready)
      evq.push_back({27'd0, evt_index, evt_level});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_evt(input string tag, input logic [3:0] idx, input logic lvl);
    logic [31:0] got;
    got = (evq.size() > 0) ? evq.pop_front() : 32'hFFFF_FFFF;
    chk(tag, got, {27'd0, idx, lvl});
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {sw_stable, 12'd0, evt_valid, evt_index, evt_level, evt_overrun}, 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    sw        = '0;
    evt_ready = 1'b0;
    tick(3);
    chk_outs_zero("reset_outs");

    // Reset release and single whack on sw[6]
    reset_n   = 1'b1;
    evt_ready = 1'b1;
    tick(2);
    sw[6] = 1'b1;
    tick(5);
    chk_outs_zero("whack_pre_e5");
    tick(1);
    chk("whack_stable_e6", sw_stable, 16'h0040);
    chk("whack_valid_e6", evt_valid, 0);
    tick(1);
    chk("whack_evt_e7", {evt_valid, evt_index, evt_level}, {1'b1, 4'd6, 1'b1});
    tick(1);
    chk("whack_valid_e8", evt_valid, 0);
    chk_evt("whack_q", 4'd6, 1'b1);

    // Bounce: 1,0,1 every 2 cycles, then hold
    sw[3] = 1'b1;
    tick(2);
    sw[3] = 1'b0;
    tick(2);
    sw[3] = 1'b1;
    tick(5);
    chk("bounce_stable_e9", sw_stable[3], 0);
    tick(1);
    chk("bounce_stable_e10", sw_stable[3], 1);
    tick(6);
    chk_evt("bounce_q", 4'd3, 1'b1);
    chk("bounce_qsize", evq.size(), 0);

    // Simultaneous changes on sw[14] and sw[1]
    sw[14] = 1'b1;
    sw[1]  = 1'b1;
    tick(7);
    chk("simul_e7", {evt_valid, evt_index, evt_level}, {1'b1, 4'd1, 1'b1});
    tick(1);
    chk("simul_e8", evt_valid, 0);
    tick(1);
    chk("simul_e9", {evt_valid, evt_index, evt_level}, {1'b1, 4'd14, 1'b1});
    tick(3);
    chk_evt("simul_q0", 4'd1, 1'b1);
    chk_evt("simul_q1", 4'd14, 1'b1);

    // Backpressure and overrun
    evt_ready = 1'b0;
    sw[8] = 1'b1;
    tick(7);
    chk("bp_hold8", {evt_valid, evt_index, evt_level}, {1'b1, 4'd8, 1'b1});
    sw[5] = 1'b1;
    tick(8);
    chk("bp_stable5", sw_stable[5], 1);
    chk("bp_hold8b", {evt_valid, evt_index, evt_level}, {1'b1, 4'd8, 1'b1});
    chk("bp_no_ovr", evt_overrun, 0);
    sw[5] = 1'b0;
    tick(8);
    chk("bp_stable5_lo", sw_stable[5], 0);
    chk("bp_ovr", evt_overrun, 1);
    chk("bp_hold8c", {evt_valid, evt_index, evt_level}, {1'b1, 4'd8, 1'b1});
    chk("bp_qempty", evq.size(), 0);
    evt_ready = 1'b1;
    tick(6);
    chk_evt("bp_q0", 4'd8, 1'b1);
    chk_evt("bp_q1", 4'd5, 1'b0);
    chk("bp_qsize", evq.size(), 0);
    chk("bp_ovr_sticky", evt_overrun, 1);

    // Release event on sw[10]
    sw[10] = 1'b1;
    tick(10);
    chk_evt("rel_up", 4'd10, 1'b1);
    sw[10] = 1'b0;
    tick(10);
    chk_evt("rel_down", 4'd10, 1'b0);
    chk("rel_qsize", evq.size(), 0);

    // Reset mid-handshake and mid-count
    evt_ready = 1'b0;
    sw[11] = 1'b1;
    tick(7);
    chk("mid_valid11", {evt_valid, evt_index}, {1'b1, 4'd11});
    sw[12] = 1'b1;
    tick(4);
    #3;
    reset_n = 1'b0;
    #1;
    chk_outs_zero("mid_async_rst");
    sw        = 16'h8000;
    evt_ready = 1'b1;
    tick(2);
    chk_outs_zero("mid_rst_hold");
    evq.delete();
    reset_n = 1'b1;
    tick(6);
    chk("mid_e6", {sw_stable, 12'd0, evt_valid, evt_index, evt_level},
        {16'h8000, 12'd0, 1'b0, 4'd0, 1'b0});
    tick(1);
    chk("mid_e7", {evt_valid, evt_index, evt_level}, {1'b1, 4'd15, 1'b1});
    tick(4);
    chk_evt("mid_q", 4'd15, 1'b1);
    chk("mid_qsize", evq.size(), 0);
    chk("mid_ovr", evt_overrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
